mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
Memory-stage controller that produces the MEM/WB pipeline-register inputs (mem_rd_mux, wb_enable, alu_result, mem_result) of the 16-bit RSA ASIP pipeline.
- Takes EX/MEM fields and runs loads/stores against data memory over a req/ack handshake.
- Stalls upstream stages while an access is outstanding.
- Signals each retired instruction to MEM/WB with a one-cycle valid pulse.

Parameters:
ARQ, 16, datapath and address width
TIMEOUT, 15, cycles without mem_ack before an access is aborted

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
valid_in  in  1  EX/MEM holds a live instruction
mem_rd_in  in  1  load request
mem_wr_in  in  1  store request
wb_enable_in  in  1  instruction writes register file
mem_rd_mux_in  in  1  writeback source select (1 = memory)
alu_result_in  in  ARQ  ALU result / memory address
store_data_in  in  ARQ  store data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ARQ  memory address
mem_wdata  out  ARQ  memory write data
mem_ack  in  1  memory response, one-cycle pulse
mem_rdata  in  ARQ  read data, valid with mem_ack
valid_out  out  1  one-cycle pulse per retired instruction
mem_rd_mux_out  out  1  to MEM/WB
wb_enable_out  out  1  to MEM/WB, qualified by valid_out
alu_result_out  out  ARQ  to MEM/WB
mem_result_out  out  ARQ  to MEM/WB
stall  out  1  freeze IF/ID/EX and EX/MEM
mem_err  out  1  sticky access-timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, and every output 0: mem_req, mem_we, mem_addr, mem_wdata, valid_out, mem_rd_mux_out, wb_enable_out, alu_result_out, mem_result_out, mem_err. stall is combinational and reads 0 in IDLE with valid_in=0.
- Reset mid-access: mem_req drops immediately; the captured instruction is discarded.
- States: IDLE and ACCESS.
- IDLE, valid_in=1, no rd/wr:
  - Fields are registered at the next edge; mem_result_out=0; valid_out=1 for one cycle.
  - Latency 1; stall=0.
- IDLE, valid_in=1, rd or wr:
  - stall=1 in the same cycle (combinational).
  - Next edge: capture all fields, go to ACCESS, mem_req=1, mem_addr=alu_result_in, mem_we=mem_wr_in, mem_wdata=store_data_in.
  - rd and wr both set: write takes priority, no read is performed.
- ACCESS:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - stall = !mem_ack.
  - Counter increments every cycle without mem_ack.
- mem_ack in ACCESS, registered at the edge:
  - mem_result_out = mem_rdata for a load, 0 for a store.
  - alu_result_out, mem_rd_mux_out and wb_enable_out come from the captured fields.
  - valid_out=1, mem_req=0, counter cleared, go to IDLE.
  - Minimum load/store latency: 2 cycles after valid_in when ack arrives in the first ACCESS cycle.
- Timeout: counter reaches TIMEOUT without ack:
  - Go to IDLE, mem_req=0, mem_err=1 (sticky until reset).
  - valid_out=1 with wb_enable_out=0 and mem_result_out=0.
  - stall=0 in that cycle.
- mem_ack in IDLE is ignored; mem_rdata is ignored without mem_ack.
- wb_enable_out=0 whenever valid_out=0, so the register file never writes twice. Other MEM/WB outputs hold their last value.
- valid_in while stall=1 is not sampled; upstream holds it stable.
- Back-to-back accesses: after the ack cycle the stage is in IDLE and accepts the next instruction on the following edge. There is no combinational path from mem_ack to mem_req.
- Counter width is clog2(TIMEOUT+1) and it never wraps.

Decomposition:
- Package rsa_pipe_pkg:
  - default ARQ
  - state enum {IDLE, ACCESS}
  - DEFAULT_MEM_TIMEOUT constant
  - struct for the captured EX/MEM fields (rd, wr, wb_enable, rd_mux, alu_result, store_data)
- One sub-module, mem_timeout_cnt:
  - Inputs: clk, rst, clear, enable.
  - Output: expired.
  - Same async active-low reset.

Test Plan:
- Reset: hold rst=0 with arbitrary inputs -> all outputs 0. Assert rst=0 mid-ACCESS -> mem_req falls with no clock edge.
- ALU pass-through: valid_in=1, rd=wr=0, wb_enable_in=1, alu_result_in=16'd1110 -> next cycle valid_out=1, wb_enable_out=1, alu_result_out=1110, mem_result_out=0, stall stays 0.
- Load with 3-cycle memory wait: rd=1, mem_rd_mux_in=1, alu_result_in=16'd1110, ack on the 3rd ACCESS cycle with mem_rdata=16'd1874:
  - mem_addr=1110 and mem_we=0 throughout.
  - stall high until the ack cycle.
  - Then valid_out=1, mem_result_out=1874, mem_rd_mux_out=1.
- Store: wr=1, store_data_in=16'hBEEF, wb_enable_in=0, immediate ack -> mem_we=1, mem_wdata=BEEF, valid_out one cycle, wb_enable_out=0, mem_result_out=0.
- Timeout: load with no ack, TIMEOUT=15 -> after 15 ACCESS cycles mem_req=0, mem_err=1, valid_out=1 with wb_enable_out=0. mem_err stays 1 across later good accesses until reset.
- Back-to-back loads, plus a stray mem_ack while IDLE -> two distinct valid_out pulses with correct data, and the stray ack has no effect.

Source files
------------

// File: rtl/rsa_pipe_pkg.sv
// Shared types and defaults for the RSA ASIP pipeline memory stage.
// Holds constants and types only: no latency, no flow control.
package rsa_pipe_pkg;

  localparam int DEFAULT_ARQ         = 16;
  localparam int DEFAULT_MEM_TIMEOUT = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  // EX/MEM fields held for the duration of a memory access.
  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic                   wb_enable;
    logic                   rd_mux;
    logic [DEFAULT_ARQ-1:0] alu_result;
    logic [DEFAULT_ARQ-1:0] store_data;
  } exmem_fields_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access watchdog: expired is combinational on the TIMEOUT-th enabled cycle, then self-clears.
// Latency 0 on expired; no backpressure, counts while enable is high and never wraps.
module mem_timeout_cnt
  import rsa_pipe_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Fires while the final allowed cycle is still running, so the abort lands on its edge.
  assign expired = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || expired) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over req/ack and feeds MEM/WB; ALU ops retire in 1 cycle, accesses in 2+.
// Backpressure: stall holds upstream while an access is outstanding; accesses abort after TIMEOUT cycles.
module mem_access_stage
  import rsa_pipe_pkg::*;
#(
  parameter int ARQ     = DEFAULT_ARQ,
  parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_in,
  input  logic           mem_rd_in,
  input  logic           mem_wr_in,
  input  logic           wb_enable_in,
  input  logic           mem_rd_mux_in,
  input  logic [ARQ-1:0] alu_result_in,
  input  logic [ARQ-1:0] store_data_in,
  output logic           mem_req,
  output logic           mem_we,
  output logic [ARQ-1:0] mem_addr,
  output logic [ARQ-1:0] mem_wdata,
  input  logic           mem_ack,
  input  logic [ARQ-1:0] mem_rdata,
  output logic           valid_out,
  output logic           mem_rd_mux_out,
  output logic           wb_enable_out,
  output logic [ARQ-1:0] alu_result_out,
  output logic [ARQ-1:0] mem_result_out,
  output logic           stall,
  output logic           mem_err
);

  mem_state_e    state_q, state_d;
  exmem_fields_t cap_q, cap_d;

  logic           req_d, we_d, vld_d, mux_d, wb_d, err_d;
  logic [ARQ-1:0] addr_d, wdata_d, alu_d, res_d;
  logic           expired;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state_q != ACCESS) || mem_ack),
    .enable  ((state_q == ACCESS) && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cap_q          <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      valid_out      <= 1'b0;
      mem_rd_mux_out <= 1'b0;
      wb_enable_out  <= 1'b0;
      alu_result_out <= '0;
      mem_result_out <= '0;
      mem_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cap_q          <= cap_d;
      mem_req        <= req_d;
      mem_we         <= we_d;
      mem_addr       <= addr_d;
      mem_wdata      <= wdata_d;
      valid_out      <= vld_d;
      mem_rd_mux_out <= mux_d;
      wb_enable_out  <= wb_d;
      alu_result_out <= alu_d;
      mem_result_out <= res_d;
      mem_err        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    vld_d   = 1'b0;
    wb_d    = 1'b0;
    mux_d   = mem_rd_mux_out;
    alu_d   = alu_result_out;
    res_d   = mem_result_out;
    err_d   = mem_err;
    stall   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in && (mem_rd_in || mem_wr_in)) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cap_d   = '{rd: mem_rd_in, wr: mem_wr_in, wb_enable: wb_enable_in,
                      rd_mux: mem_rd_mux_in, alu_result: alu_result_in,
                      store_data: store_data_in};
          req_d   = 1'b1;
          we_d    = mem_wr_in;
          addr_d  = alu_result_in;
          wdata_d = store_data_in;
        end else if (valid_in) begin
          vld_d = 1'b1;
          wb_d  = wb_enable_in;
          mux_d = mem_rd_mux_in;
          alu_d = alu_result_in;
          res_d = '0;
        end
      end
      ACCESS: begin
        stall = !mem_ack;
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          vld_d   = 1'b1;
          wb_d    = cap_q.wb_enable;
          mux_d   = cap_q.rd_mux;
          alu_d   = cap_q.alu_result;
          // A write wins over a simultaneous read, so only a pure load returns data.
          res_d   = (cap_q.rd && !cap_q.wr) ? mem_rdata : '0;
        end else if (expired) begin
          stall   = 1'b0;
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          vld_d   = 1'b1;
          wb_d    = 1'b0;
          mux_d   = cap_q.rd_mux;
          alu_d   = cap_q.alu_result;
          res_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
